comp_arbiter: RTL and testbench
===============================

# comp_arbiter

Two-port arbiter and sequencer for the shared 32-bit signed/unsigned comparison datapath in the branch-resolution path. Two requesters (fetch-side early branch check, execute-side branch unit) present operand pairs with a 3-bit compare op through valid/ready handshakes. A round-robin grant selects one per cycle; the comparison result is registered into a single response channel tagged with requester id and a caller tag. The block owns the comparison datapath internally, with the team's standard compare-op encoding.

## Interface

Parameters:
- WIDTH, 32, operand width
- TAGW, 4, caller tag width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 has a compare pending
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req0_a, req0_b  in  WIDTH  operands
- req0_op  in  3  compare op
- req0_tag  in  TAGW  caller tag, returned unchanged
- req1_valid / req1_ready / req1_a / req1_b / req1_op / req1_tag: same as requester 0
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes response this cycle
- rsp_id  out  1  requester that issued the response
- rsp_tag  out  TAGW  tag of that request
- rsp_result  out  1  compare outcome
- rsp_err  out  1  op was illegal

## Operation

- Op encoding: 000 a==b; 001 signed a>=b; 010 signed a<=b; 011 signed a>b; 100 signed a<b; 101 a!=b; 110/111 illegal -> rsp_result=0, rsp_err=1.
- Transfer on a port: reqN_valid & reqN_ready at a rising edge.
- can_accept = ~rsp_valid | rsp_ready (combinational).
- Grant:
  - Only one valid: that port wins.
  - Both valid: the port not in last_grant wins.
  - reqN_ready = can_accept & grant_N. At most one ready high per cycle.
  - reqN_ready may depend on reqN_valid; requesters must not make valid depend on ready.
- last_grant register: updated to the winning id on every transfer, otherwise held.
- Response register (rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_err):
  - Transfer: loads comparison of granted operands; rsp_valid=1.
  - No transfer and rsp_ready: rsp_valid=0; payload fields hold stale values.
  - No transfer and no rsp_ready: all fields hold.
- Simultaneous consume and accept: new result replaces old in the same edge; rsp_valid stays 1.
- Requesters must hold operands, op and tag stable while valid is high and not accepted. The arbiter re-evaluates every cycle; a requester's grant may move to the other port only if that requester dropped valid.
- Stats: none. No internal FIFO; depth is exactly one response.

## Timing

- Reset (async assert, sync deassert by the clock domain): rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_err=0, last_grant=1. Requester 0 wins the first contended cycle.
- req ready outputs are 0 while rst is high.
- Latency: transfer at edge N -> rsp_valid and payload visible after edge N, consumable at edge N+1.
- Throughput: one compare per cycle when rsp_ready is held high.
- Backpressure: rsp_valid=1 with rsp_ready=0 forces both reqN_ready=0; last_grant holds.
- Fairness: with both ports continuously valid and rsp_ready=1, grants alternate 0,1,0,1…. Worst-case wait is one transfer.
- Reset mid-operation: a held response is discarded immediately; pending requests are not accepted until after reset deasserts.

## Test plan

- Reset, then req0 only: a=5, b=5, op=000, tag=3 -> req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_tag=3, rsp_result=1, rsp_err=0.
- Signed ops: a=0xFFFFFFFF (-1), b=1 on ops 001..100 -> results 0,1,0,1. op=101 with a=b -> 0. op=110 -> rsp_result=0, rsp_err=1.
- Contention: both ports valid for 6 cycles, rsp_ready=1, distinct tags -> rsp_id sequence 0,1,0,1,0,1, one response per cycle, tags in order per port.
- Backpressure: fill the response register, hold rsp_ready=0 for 3 cycles with both ports valid -> both readys 0, response fields stable. Raise rsp_ready -> same-edge replacement, rsp_valid stays 1, next winner is the port after last_grant.
- Async reset while rsp_valid=1 and both ports valid -> rsp_valid falls without a clock edge, all outputs 0. After deassert, first contended grant goes to port 0.

Source files
------------

// File: rtl/comp_arbiter_if.sv
// rtl/comp_arbiter_if.sv - requester and response handshake bundle for comp_arbiter
interface comp_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  logic [TAGW-1:0]  req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;
  logic [TAGW-1:0]  req1_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [TAGW-1:0]  rsp_tag;
  logic             rsp_result;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op, req1_tag,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, req1_tag,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/comp_arbiter.sv
// rtl/comp_arbiter.sv - round-robin two-port arbiter over a registered compare datapath
module comp_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  comp_arbiter_if.slave bus
);

  logic            last_grant_q, last_grant_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic            rsp_result_q, rsp_result_d;
  logic            rsp_err_q, rsp_err_d;

  logic             can_accept;
  logic             grant0, grant1;
  logic             ready0, ready1;
  logic             xfer;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_op;
  logic [TAGW-1:0]  sel_tag;
  logic [1:0]       cmp;

  // Returns {err, result}.
  function automatic logic [1:0] compare_op(input logic [2:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [1:0] r;
    r = 2'b00;
    case (op)
      3'b000:  r[0] = (a == b);
      3'b001:  r[0] = ($signed(a) >= $signed(b));
      3'b010:  r[0] = ($signed(a) <= $signed(b));
      3'b011:  r[0] = ($signed(a) >  $signed(b));
      3'b100:  r[0] = ($signed(a) <  $signed(b));
      3'b101:  r[0] = (a != b);
      default: r    = 2'b10;
    endcase
    return r;
  endfunction

  always_comb begin
    can_accept = ~rsp_valid_q | bus.rsp_ready;
    // Under contention the port that did not win last time goes first.
    grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    ready0 = can_accept & grant0 & ~rst;
    ready1 = can_accept & grant1 & ~rst;
    xfer   = ready0 | ready1;

    sel_a   = grant1 ? bus.req1_a   : bus.req0_a;
    sel_b   = grant1 ? bus.req1_b   : bus.req0_b;
    sel_op  = grant1 ? bus.req1_op  : bus.req0_op;
    sel_tag = grant1 ? bus.req1_tag : bus.req0_tag;
    cmp     = compare_op(sel_op, sel_a, sel_b);

    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;

    if (xfer) begin
      last_grant_d = ready1;
      rsp_valid_d  = 1'b1;
      rsp_id_d     = ready1;
      rsp_tag_d    = sel_tag;
      rsp_result_d = cmp[0];
      rsp_err_d    = cmp[1];
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_result_q <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_comp_arbiter.sv
// tb/tb_comp_arbiter.sv - directed bench for comp_arbiter with a reference response model
module tb_comp_arbiter;

  logic clk = 1'b0;
  logic rst;

  comp_arbiter_if #(.WIDTH(32), .TAGW(4)) bus ();

  comp_arbiter #(.WIDTH(32), .TAGW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one response slot, previous winner, compare semantics on plain integers.
  logic       m_valid = 1'b0;
  logic       m_id    = 1'b0;
  logic [3:0] m_tag   = 4'd0;
  logic       m_res   = 1'b0;
  logic       m_err   = 1'b0;
  logic       m_last  = 1'b1;
  logic [1:0] m_win;
  logic       m_ok, m_rdy0, m_rdy1;
  logic [1:0] m_cmp;

  function automatic logic [1:0] ref_cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return {1'b0, a == b};
      3'd1: return {1'b0, sa >= sb};
      3'd2: return {1'b0, sa <= sb};
      3'd3: return {1'b0, sa > sb};
      3'd4: return {1'b0, sa < sb};
      3'd5: return {1'b0, a != b};
      default: return 2'b10;
    endcase
  endfunction

  always_comb begin
    m_win = 2'd2;
    if (bus.req0_valid && bus.req1_valid) m_win = m_last ? 2'd0 : 2'd1;
    else if (bus.req0_valid)              m_win = 2'd0;
    else if (bus.req1_valid)              m_win = 2'd1;
    m_ok   = !m_valid || bus.rsp_ready;
    m_rdy0 = !rst && m_ok && (m_win == 2'd0);
    m_rdy1 = !rst && m_ok && (m_win == 2'd1);
    m_cmp  = (m_win == 2'd1) ? ref_cmp(bus.req1_op, bus.req1_a, bus.req1_b)
                             : ref_cmp(bus.req0_op, bus.req0_a, bus.req0_b);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_id    <= 1'b0;
      m_tag   <= 4'd0;
      m_res   <= 1'b0;
      m_err   <= 1'b0;
      m_last  <= 1'b1;
    end else if (m_rdy0 || m_rdy1) begin
      m_valid <= 1'b1;
      m_id    <= m_rdy1;
      m_tag   <= m_rdy1 ? bus.req1_tag : bus.req0_tag;
      m_res   <= m_cmp[0];
      m_err   <= m_cmp[1];
      m_last  <= m_rdy1;
    end else if (bus.rsp_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("req0_ready", bus.req0_ready, m_rdy0);
    check("req1_ready", bus.req1_ready, m_rdy1);
    check("rsp_valid",  bus.rsp_valid,  m_valid);
    check("rsp_id",     bus.rsp_id,     m_id);
    check("rsp_tag",    bus.rsp_tag,    m_tag);
    check("rsp_result", bus.rsp_result, m_res);
    check("rsp_err",    bus.rsp_err,    m_err);
  end

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [3:0] tag);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_tag = tag;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [3:0] tag);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_tag = tag;
  endtask

  logic [31:0] s_a   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd9};
  logic [31:0] s_b   [6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd7, 32'd2};
  logic [2:0]  s_op  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
  logic        s_res [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        s_err [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        c_id  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0]  c_tag [6] = '{4'd8, 4'd12, 4'd9, 4'd13, 4'd10, 4'd14};

  initial begin
    logic [3:0] t0, t1;
    logic r0, r1;
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    set0(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
    set1(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_tag", bus.rsp_tag, 4'd0);
    set0(1'b1, 32'd5, 32'd5, 3'd0, 4'd3);
    #1;
    check("reset_ready0_held_low", bus.req0_ready, 1'b0);

    // Single request on port 0.
    @(negedge clk); #2;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    check("t1_ready0", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    set0(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
    check("t1_rsp_valid", bus.rsp_valid, 1'b1);
    check("t1_rsp_id", bus.rsp_id, 1'b0);
    check("t1_rsp_tag", bus.rsp_tag, 4'd3);
    check("t1_rsp_result", bus.rsp_result, 1'b1);
    check("t1_rsp_err", bus.rsp_err, 1'b0);

    // Signed and illegal ops, back to back on port 1.
    for (int i = 0; i < 6; i++) begin
      set1(1'b1, s_a[i], s_b[i], s_op[i], 4'(i));
      @(posedge clk); #1;
      check("op_result", bus.rsp_result, s_res[i]);
      check("op_err", bus.rsp_err, s_err[i]);
      check("op_id", bus.rsp_id, 1'b1);
      check("op_tag", bus.rsp_tag, 4'(i));
    end
    set1(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);

    // Contention: grants alternate starting with port 0.
    t0 = 4'd8;
    t1 = 4'd12;
    set0(1'b1, 32'(t0), 32'(t0), 3'd0, t0);
    set1(1'b1, 32'(t1), 32'd0, 3'd3, t1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      @(posedge clk); #1;
      check("rr_valid", bus.rsp_valid, 1'b1);
      check("rr_id", bus.rsp_id, c_id[k]);
      check("rr_tag", bus.rsp_tag, c_tag[k]);
      if (r0) begin t0 = t0 + 4'd1; set0(1'b1, 32'(t0), 32'(t0), 3'd0, t0); end
      if (r1) begin t1 = t1 + 4'd1; set1(1'b1, 32'(t1), 32'd0, 3'd3, t1); end
    end

    // Backpressure with both ports pending.
    bus.rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("bp_ready0", bus.req0_ready, 1'b0);
      check("bp_ready1", bus.req1_ready, 1'b0);
      check("bp_valid", bus.rsp_valid, 1'b1);
      check("bp_tag", bus.rsp_tag, 4'd14);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready0", bus.req0_ready, 1'b1);
    check("bp_release_ready1", bus.req1_ready, 1'b0);
    @(posedge clk); #1;
    check("bp_replace_valid", bus.rsp_valid, 1'b1);
    check("bp_replace_id", bus.rsp_id, 1'b0);
    check("bp_replace_tag", bus.rsp_tag, 4'd11);
    t0 = t0 + 4'd1;
    set0(1'b1, 32'(t0), 32'(t0), 3'd0, t0);

    // Async reset while a response is held.
    bus.rsp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", bus.rsp_valid, 1'b0);
    check("arst_id", bus.rsp_id, 1'b0);
    check("arst_tag", bus.rsp_tag, 4'd0);
    check("arst_result", bus.rsp_result, 1'b0);
    check("arst_err", bus.rsp_err, 1'b0);
    check("arst_ready0", bus.req0_ready, 1'b0);
    check("arst_ready1", bus.req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    check("post_rst_ready0", bus.req0_ready, 1'b1);
    check("post_rst_ready1", bus.req1_ready, 1'b0);
    @(posedge clk); #1;
    set0(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
    set1(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
    check("post_rst_id", bus.rsp_id, 1'b0);
    check("post_rst_tag", bus.rsp_tag, 4'd12);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
